// File: rtl/fir_seq_pkg.sv
// fir_seq_pkg: shared widths, FSM encoding and result lane indexing for the block FIR sequencer
package fir_seq_pkg;
   localparam int IN_SAMPLE_WIDTH  = 16;
   localparam int OUT_SAMPLE_WIDTH = 32;
   typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
   // The filter returns results in reverse lane order: sample 0's result sits in the top lane.
   // Out-of-range indices map to lane 0 so the caller never selects past the vector.
   function automatic int unsigned lane_of(input int unsigned idx, input int unsigned n);
      return (idx < n) ? n - 1 - idx : 0;
   endfunction
endpackage

// File: rtl/fir_result_serializer.sv
// fir_result_serializer: captures one block of filter results and streams them out lane by lane
//   clkIn/nResetIn : clock, async active-low reset
//   load_i, data_i : capture strobe and packed result block from the filter
//   ready_i        : downstream accepts result_o
//   valid_o        : result_o valid (results still pending)
//   result_o       : current result, zero when nothing is pending
module fir_result_serializer
   import fir_seq_pkg::*;
#(
   parameter int unsigned SAMPLES_NUM = 4
) (
   input  logic                                    clkIn,
   input  logic                                    nResetIn,
   input  logic                                    load_i,
   input  logic [OUT_SAMPLE_WIDTH*SAMPLES_NUM-1:0] data_i,
   input  logic                                    ready_i,
   output logic                                    valid_o,
   output logic [OUT_SAMPLE_WIDTH-1:0]             result_o
);
   localparam int CW = $clog2(SAMPLES_NUM + 1);
   localparam logic [CW-1:0] FULL = CW'(SAMPLES_NUM);
   logic [OUT_SAMPLE_WIDTH*SAMPLES_NUM-1:0] out_q, out_d;
   logic [CW-1:0] cnt_q, cnt_d, idx_q, idx_d;
   logic fire;
   assign valid_o = cnt_q != '0;
   assign fire    = valid_o && ready_i;
   always_comb begin
      result_o = '0;
      for (int unsigned l = 0; l < SAMPLES_NUM; l++)
         if (valid_o && l == lane_of(32'(idx_q), SAMPLES_NUM)) result_o = out_q[OUT_SAMPLE_WIDTH*l +: OUT_SAMPLE_WIDTH];
   end
   always_comb begin
      out_d = load_i ? data_i : out_q;
      cnt_d = load_i ? FULL : fire ? cnt_q - 1'b1 : cnt_q;
      idx_d = load_i ? '0 : fire ? idx_q + 1'b1 : idx_q;
   end
   always_ff @(posedge clkIn or negedge nResetIn) begin
      if (!nResetIn) begin
         out_q <= '0;
         cnt_q <= '0;
         idx_q <= '0;
      end else begin
         out_q <= out_d;
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end
endmodule

// File: rtl/fir_block_sequencer.sv
// fir_block_sequencer: packs a sample stream into blocks, launches the block FIR and streams its results back
//   clkIn/nResetIn                      : clock, async active-low reset
//   sampleIn/sampleValidIn/sampleReadyOut : input sample stream
//   resultOut/resultValidOut/resultReadyIn: output result stream
//   firStartOut/firDataOut              : one-cycle start pulse and launched block to the filter
//   firBusyIn/firDoneIn/firDataIn       : filter status and results
//   errorOut                            : sticky protocol error
module fir_block_sequencer
   import fir_seq_pkg::*;
#(
   parameter int unsigned SAMPLES_NUM = 4
) (
   input  logic                                    clkIn,
   input  logic                                    nResetIn,
   input  logic [IN_SAMPLE_WIDTH-1:0]              sampleIn,
   input  logic                                    sampleValidIn,
   output logic                                    sampleReadyOut,
   output logic [OUT_SAMPLE_WIDTH-1:0]             resultOut,
   output logic                                    resultValidOut,
   input  logic                                    resultReadyIn,
   output logic                                    firStartOut,
   output logic [IN_SAMPLE_WIDTH*SAMPLES_NUM-1:0]  firDataOut,
   input  logic                                    firBusyIn,
   input  logic                                    firDoneIn,
   input  logic [OUT_SAMPLE_WIDTH*SAMPLES_NUM-1:0] firDataIn,
   output logic                                    errorOut
);
   localparam int CW = $clog2(SAMPLES_NUM + 1);
   localparam int PW = IN_SAMPLE_WIDTH * SAMPLES_NUM;
   localparam logic [CW-1:0] LAST = CW'(SAMPLES_NUM - 1);
   state_t state_q, state_d;
   logic [PW-1:0] pack_q, pack_d, launch_q, launch_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic full_q, full_d, low_q, low_d, err_q, err_d;
   logic accept, launch, capture;
   assign sampleReadyOut = !full_q;
   assign accept         = sampleValidIn && !full_q;
   // Launch only once the previous block's results have fully drained.
   assign launch         = state_q == IDLE && full_q && !resultValidOut && !firBusyIn;
   assign firDataOut     = launch_q;
   assign errorOut       = err_q;
   always_ff @(posedge clkIn or negedge nResetIn) begin
      if (!nResetIn) state_q <= IDLE;
      else state_q <= state_d;
   end
   always_comb begin
      state_d = launch ? START : state_q == START ? WAIT : capture ? IDLE : state_q;
   end
   always_comb begin
      firStartOut = state_q == START;
      capture     = state_q == WAIT && firDoneIn;
   end
   always_comb begin
      pack_d = pack_q;
      for (int unsigned k = 0; k < SAMPLES_NUM; k++)
         if (accept && cnt_q == CW'(k)) pack_d[IN_SAMPLE_WIDTH*k +: IN_SAMPLE_WIDTH] = sampleIn;
      cnt_d    = launch ? '0 : accept ? (cnt_q == LAST ? '0 : cnt_q + 1'b1) : cnt_q;
      full_d   = launch ? 1'b0 : (accept && cnt_q == LAST) ? 1'b1 : full_q;
      launch_d = launch ? pack_q : launch_q;
      // Busy low in WAIT without done; two such cycles in a row flag a filter that dropped the block.
      low_d    = state_q == WAIT && !firBusyIn && !firDoneIn;
      err_d    = err_q | (firDoneIn && state_q != WAIT) | (low_q && low_d);
   end
   always_ff @(posedge clkIn or negedge nResetIn) begin
      if (!nResetIn) begin
         pack_q   <= '0;
         launch_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         low_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         pack_q   <= pack_d;
         launch_q <= launch_d;
         cnt_q    <= cnt_d;
         full_q   <= full_d;
         low_q    <= low_d;
         err_q    <= err_d;
      end
   end
   fir_result_serializer #(.SAMPLES_NUM(SAMPLES_NUM)) u_ser (
      .clkIn    (clkIn),
      .nResetIn (nResetIn),
      .load_i   (capture),
      .data_i   (firDataIn),
      .ready_i  (resultReadyIn),
      .valid_o  (resultValidOut),
      .result_o (resultOut)
   );
endmodule

// File: tb/tb_fir_block_sequencer.sv
// tb_fir_block_sequencer: directed bench with a behavioural filter and a result scoreboard
module tb_fir_block_sequencer;
   localparam int N = 4;
   logic clkIn = 1'b0, nResetIn = 1'b0;
   logic [15:0] sampleIn = '0;
   logic sampleValidIn = 1'b0, sampleReadyOut;
   logic [31:0] resultOut;
   logic resultValidOut, resultReadyIn = 1'b0;
   logic firStartOut;
   logic [16*N-1:0] firDataOut;
   logic firBusyIn, firDoneIn;
   logic [32*N-1:0] firDataIn;
   logic errorOut;
   logic m_busy = 1'b0, m_done = 1'b0, m_run = 1'b0, spur_done = 1'b0, drop_busy = 1'b0;
   int m_cnt = 0;
   logic [32*N-1:0] m_data = '0;
   logic [31:0] exp_q[$];
   int total = 0, bad = 0;

   assign firBusyIn = m_busy;
   assign firDoneIn = m_done | spur_done;
   assign firDataIn = m_data;

   always #5 clkIn = ~clkIn;

   fir_block_sequencer #(.SAMPLES_NUM(N)) dut (
      .clkIn(clkIn), .nResetIn(nResetIn),
      .sampleIn(sampleIn), .sampleValidIn(sampleValidIn), .sampleReadyOut(sampleReadyOut),
      .resultOut(resultOut), .resultValidOut(resultValidOut), .resultReadyIn(resultReadyIn),
      .firStartOut(firStartOut), .firDataOut(firDataOut),
      .firBusyIn(firBusyIn), .firDoneIn(firDoneIn), .firDataIn(firDataIn),
      .errorOut(errorOut)
   );

   function automatic logic [31:0] dbl(input logic [15:0] s);
      return {{15{s[15]}}, s, 1'b0};
   endfunction

   function automatic logic [32*N-1:0] filt(input logic [16*N-1:0] b);
      logic [32*N-1:0] r;
      r = '0;
      for (int k = 0; k < N; k++) r[32*(N-1-k) +: 32] = dbl(b[16*k +: 16]);
      return r;
   endfunction

   // Behavioural filter: done 20 cycles after start, each lane doubles its sample.
   always @(posedge clkIn or negedge nResetIn) begin
      if (!nResetIn) begin
         m_run <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0; m_data <= '0;
      end else begin
         m_done <= 1'b0;
         if (firStartOut) begin
            m_run <= 1'b1; m_busy <= !drop_busy; m_cnt <= 20; m_data <= filt(firDataOut);
         end else if (m_run) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin m_run <= 1'b0; m_busy <= 1'b0; m_done <= 1'b1; end
         end
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic send(input logic [15:0] x);
      int t = 0;
      sampleIn = x;
      sampleValidIn = 1'b1;
      while (!sampleReadyOut && t < 100) begin @(negedge clkIn); t++; end
      if (t >= 100) chk("send_timeout", sampleReadyOut, 1);
      @(posedge clkIn);
      exp_q.push_back(dbl(x));
      @(negedge clkIn);
      sampleValidIn = 1'b0;
   endtask

   task automatic drain(input int n, input bit toggle);
      int got = 0;
      for (int c = 0; c < 200 && got < n; c++) begin
         @(negedge clkIn);
         resultReadyIn = toggle ? c[0] : 1'b1;
         #1;
         if (resultValidOut && resultReadyIn) begin
            chk("result", resultOut, exp_q.size() != 0 ? exp_q.pop_front() : 32'hxxxx_xxxx);
            got++;
         end
      end
      chk("drain_count", got, n);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int t;
      logic seen;
      repeat (3) @(negedge clkIn);
      chk("rst_ready", sampleReadyOut, 1);
      chk("rst_valid", resultValidOut, 0);
      chk("rst_result", resultOut, 0);
      chk("rst_start", firStartOut, 0);
      chk("rst_data", firDataOut, 0);
      chk("rst_err", errorOut, 0);
      nResetIn = 1'b1;
      @(negedge clkIn);
      // First block, back-to-back samples
      send(16'd1); send(16'd2); send(16'd3); send(16'd4);
      chk("full_ready", sampleReadyOut, 0);
      chk("start_early", firStartOut, 0);
      @(negedge clkIn);
      chk("start_pulse", firStartOut, 1);
      chk("launch_data", firDataOut, 64'h0004_0003_0002_0001);
      chk("ready_after_launch", sampleReadyOut, 1);
      @(negedge clkIn);
      chk("start_once", firStartOut, 0);
      chk("data_hold", firDataOut, 64'h0004_0003_0002_0001);
      drain(4, 1'b1);
      // Extreme values pass bit-exact
      @(negedge clkIn);
      resultReadyIn = 1'b0;
      send(16'h7FFF); send(16'h8000); send(16'hFFFF); send(16'h0000);
      drain(4, 1'b0);
      // Two blocks while downstream stalls
      @(negedge clkIn);
      resultReadyIn = 1'b0;
      send(16'd10); send(16'd11); send(16'd12); send(16'd13);
      send(16'hFFFE); send(16'h0100); send(16'h1234); send(16'h4000);
      chk("ready_drop", sampleReadyOut, 0);
      t = 0;
      seen = 1'b0;
      while (!resultValidOut && t < 100) begin @(negedge clkIn); seen |= firStartOut; t++; end
      chk("wait_done", resultValidOut, 1);
      repeat (5) begin @(negedge clkIn); seen |= firStartOut; end
      chk("no_early_start", seen, 0);
      chk("ready_still_low", sampleReadyOut, 0);
      drain(4, 1'b0);
      @(negedge clkIn);
      chk("gap_start", firStartOut, 0);
      chk("gap_valid", resultValidOut, 0);
      resultReadyIn = 1'b0;
      @(negedge clkIn);
      chk("second_start", firStartOut, 1);
      chk("second_data", firDataOut, 64'h4000_1234_0100_FFFE);
      drain(4, 1'b1);
      // Spurious done while idle
      @(negedge clkIn);
      resultReadyIn = 1'b0;
      chk("no_err_yet", errorOut, 0);
      spur_done = 1'b1;
      @(negedge clkIn);
      spur_done = 1'b0;
      chk("err_set", errorOut, 1);
      repeat (3) @(negedge clkIn);
      chk("err_sticky", errorOut, 1);
      // Reset mid-WAIT with a partial block pending
      send(16'd9); send(16'd10); send(16'd11); send(16'd12);
      send(16'd21); send(16'd22);
      repeat (4) @(negedge clkIn);
      nResetIn = 1'b0;
      #1;
      chk("mid_rst_ready", sampleReadyOut, 1);
      chk("mid_rst_valid", resultValidOut, 0);
      chk("mid_rst_result", resultOut, 0);
      chk("mid_rst_start", firStartOut, 0);
      chk("mid_rst_data", firDataOut, 0);
      chk("mid_rst_err", errorOut, 0);
      exp_q.delete();
      @(negedge clkIn);
      nResetIn = 1'b1;
      @(negedge clkIn);
      send(16'd5); send(16'd6); send(16'd7); send(16'd8);
      @(negedge clkIn);
      chk("post_rst_start", firStartOut, 1);
      chk("post_rst_data", firDataOut, 64'h0008_0007_0006_0005);
      drain(4, 1'b1);
      // Filter drops busy without done
      @(negedge clkIn);
      resultReadyIn = 1'b0;
      drop_busy = 1'b1;
      chk("err_clear_before", errorOut, 0);
      send(16'h0030); send(16'h0031); send(16'h0032); send(16'h0033);
      repeat (6) @(negedge clkIn);
      chk("busy_low_err", errorOut, 1);
      chk("busy_low_stay_wait", resultValidOut, 0);
      drain(4, 1'b1);
      drop_busy = 1'b0;
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fir_block_sequencer.md
# fir_block_sequencer

Stream-side initiator for the block FIR filter's start/busy/done interface. Accepts a stream of 16-bit samples, packs them into SAMPLES_NUM-lane blocks and launches the filter with a one-cycle start pulse. Captures the SAMPLES_NUM 32-bit saturated results on done and serialises them back out as a stream. Sits between the audio sample source and the filter, so the filter sees only complete blocks.

## Interface

- SAMPLES_NUM, 4, samples per block; legal 1..8, must equal the filter's SAMPLES_NUM
- clkIn  in  1  single clock; all logic on rising edge
- nResetIn  in  1  reset; one clock; reset is asynchronous and active-low
- sampleIn  in  16  signed input sample
- sampleValidIn  in  1  sampleIn valid
- sampleReadyOut  out  1  sequencer can accept a sample
- resultOut  out  32  signed filtered sample
- resultValidOut  out  1  resultOut valid
- resultReadyIn  in  1  downstream accepts resultOut
- firStartOut  out  1  start pulse to filter
- firDataOut  out  16*SAMPLES_NUM  packed block to filter
- firBusyIn  in  1  filter busy
- firDoneIn  in  1  filter done pulse
- firDataIn  in  32*SAMPLES_NUM  filter results
- errorOut  out  1  sticky protocol error

## Operation

- Reset values:
  - sampleReadyOut=1; resultValidOut=0; resultOut=0
  - firStartOut=0; firDataOut=0; errorOut=0
  - all counters 0; FSM in IDLE
- **Packer**
  - Accepts a sample on sampleValidIn && sampleReadyOut.
  - Sample k of a block (k=0 first) goes to pack[16k+15:16k].
  - packFull is set on acceptance of sample SAMPLES_NUM-1.
  - sampleReadyOut = !packFull.
- **Control FSM**
  - IDLE: if packFull && outCount==0 && !firBusyIn, go to START. Same edge: copy pack to launch register (drives firDataOut), clear packFull, reset pack count.
  - START: firStartOut=1 for exactly this cycle; go to WAIT.
  - WAIT: on firDoneIn, load firDataIn into the output register, set outCount=SAMPLES_NUM, outIdx=0, go to IDLE.
- **Serializer**
  - resultValidOut = (outCount!=0).
  - resultOut = output lane for sample outIdx = firDataIn slice [32(SAMPLES_NUM-1-outIdx)+31 : 32(SAMPLES_NUM-1-outIdx)], as captured. Sample 0's result is in the most-significant lane.
  - On resultValidOut && resultReadyIn: outIdx+1, outCount-1.
- **Errors** (errorOut sets sticky; cleared only by reset):
  - firDoneIn in any state other than WAIT.
  - firBusyIn low for 2 consecutive cycles in WAIT without firDoneIn; the FSM stays in WAIT.
- No arithmetic on sample data: values pass bit-exact, with no sign change or saturation.

## Timing

- Packing overlaps filtering: the next block is accepted while the filter runs and while results drain.
- Launch latency:
  - Last sample accepted at edge t, with idle conditions met → IDLE moves to START at t+1.
  - firStartOut high during cycle t+1..t+2; the filter samples it at edge t+2.
- firDataOut is held constant from the launch edge until the next launch.
- Done capture: firDoneIn sampled at edge d → resultValidOut high from d.
- Next launch may occur no earlier than one cycle after the final result handshake, because outCount is registered.
- Simultaneous events:
  - Sample acceptance and a launch on the same edge: the new sample is written as sample 0 of the next block.
  - Result handshake and firDoneIn on the same edge cannot occur, since outCount==0 is required to launch.
- Reset mid-operation clears everything immediately, including a pending block. The filter is reset by the same nResetIn.
- Throughput is bounded by the filter (~3 cycles per coefficient word), not by the sequencer.

## Structure

- Package fir_seq_pkg:
  - IN_SAMPLE_WIDTH=16, OUT_SAMPLE_WIDTH=32
  - state enum {IDLE, START, WAIT}
  - lane-index helper function
- Sub-module fir_result_serializer: output register, outIdx/outCount, valid/ready logic.
- Packer and FSM stay in the top module.

## Test plan

All scenarios use SAMPLES_NUM=4 with a behavioural filter model: done 20 cycles after start, result lane = sample*2 sign-extended.
- Reset → sampleReadyOut=1, resultValidOut=0, firStartOut=0, errorOut=0.
- Feed 1,2,3,4 back-to-back → firStartOut is exactly one cycle high, firDataOut=0x0004_0003_0002_0001.
- After done → results 2,4,6,8 out in order. With resultReadyIn toggling 50%, no loss or duplication.
- Feed 0x7FFF, 0x8000, -1, 0 → results 0x0000FFFE, 0xFFFF0000, 0xFFFFFFFE, 0 (bit-exact).
- Feed 8 samples continuously while resultReadyIn=0:
  - sampleReadyOut drops after sample 8.
  - The second start waits until all 4 first-block results are taken, then launches one cycle later.
- Spurious firDoneIn in IDLE → errorOut=1 sticky. Then nResetIn pulse mid-WAIT → all outputs return to reset values, errorOut=0.
